mult_hilo_ctrl: RTL and testbench



---
 rtl/mult_hilo_ctrl.sv | 122 ++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - MULT/MULTU sequencer with HI/LO registers; optional HILO_TIMEOUT_EN watchdog
module mult_hilo_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic        issue_sign,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  output logic        issue_ready,
  input  logic        rd_hi_req,
  input  logic        rd_lo_req,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic        mult_enable,
  output logic        mult_sign,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_product,
  input  logic        mult_ready,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0] state;
  logic       first_run;
  logic       run_abort;

`ifdef HILO_TIMEOUT_EN
  localparam logic [5:0] RUN_LAST = 6'(TIMEOUT_CYCLES - 1);

  logic [5:0] run_cnt;
  logic       timeout_q;

  assign run_abort   = (state == S_RUN) && (run_cnt == RUN_LAST);
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt   <= 6'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_CLEAR)
        run_cnt <= 6'd0;
      else if (state == S_RUN)
        run_cnt <= run_cnt + 6'd1;
      // a real product in the same cycle wins over the watchdog
      if (run_abort && !(mult_ready && !first_run))
        timeout_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign run_abort   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      first_run <= 1'b0;
      mult_sign <= 1'b0;
      mult_a    <= 32'd0;
      mult_b    <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            mult_sign <= issue_sign;
            mult_a    <= issue_a;
            mult_b    <= issue_b;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          first_run <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          // first RUN cycle may still see a ready left over from the previous product
          first_run <= 1'b0;
          if (mult_ready && !first_run)
            state <= S_WRITE;
          else if (run_abort)
            state <= S_IDLE;
        end
        S_WRITE: begin
          hi    <= mult_product[63:32];
          lo    <= mult_product[31:0];
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign issue_ready = (state == S_IDLE);
  assign mult_enable = (state == S_RUN) || (state == S_WRITE);
  assign stall       = busy && (issue_valid || rd_hi_req || rd_lo_req);

  always_comb begin
    rd_data = 32'd0;
    if (rd_hi_req)
      rd_data = hi;
    else if (rd_lo_req)
      rd_data = lo;
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb/tb_mult_hilo_ctrl.sv - directed-vector bench for mult_hilo_ctrl with a behavioural multiplier
module tb_mult_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_sign = 1'b0;
  logic [31:0] issue_a = 32'd0;
  logic [31:0] issue_b = 32'd0;
  logic        issue_ready;
  logic        rd_hi_req = 1'b0;
  logic        rd_lo_req = 1'b0;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic        mult_enable;
  logic        mult_sign;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [63:0] mult_product = 64'd0;
  logic        mult_ready = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout_err;

  int          n_vec = 0;
  int          n_err = 0;
  int          mdl_lat = 1;
  bit          mdl_stale = 1'b0;
  int          mdl_cnt = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  mult_hilo_ctrl #(.TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_sign(issue_sign),
    .issue_a(issue_a), .issue_b(issue_b), .issue_ready(issue_ready),
    .rd_hi_req(rd_hi_req), .rd_lo_req(rd_lo_req), .rd_data(rd_data),
    .stall(stall), .busy(busy),
    .mult_enable(mult_enable), .mult_sign(mult_sign),
    .mult_a(mult_a), .mult_b(mult_b),
    .mult_product(mult_product), .mult_ready(mult_ready),
    .hi(hi), .lo(lo), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product valid after mdl_lat enabled cycles, garbage otherwise
  always @(negedge clk) begin
    if (!mult_enable) begin
      mdl_cnt      = 0;
      mult_ready   = 1'b0;
      mult_product = 64'hBAD0_BAD0_BAD0_BAD0;
    end else begin
      mdl_cnt = mdl_cnt + 1;
      if (mdl_cnt >= mdl_lat) begin
        mult_ready = 1'b1;
        if (mult_sign)
          mult_product = $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
        else
          mult_product = {32'd0, mult_a} * {32'd0, mult_b};
      end else begin
        mult_ready   = mdl_stale && (mdl_cnt == 1);
        mult_product = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_mult(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit stale, input bit hold,
                         input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    int exp_cyc;
    bit stall_ok;
    mdl_lat   = lat;
    mdl_stale = stale;
    exp_cyc   = 2 + ((lat > 2) ? lat : 2);
    @(negedge clk);
    issue_valid = 1'b1;
    issue_sign  = sgn;
    issue_a     = a;
    issue_b     = b;
    rd_hi_req   = hold;
    #1;
    check({tag, " issue_ready"}, 64'(issue_ready), 64'd1);
    if (hold) begin
      check({tag, " pre-read hi"}, 64'(rd_data), 64'(cur_hi));
      check({tag, " idle stall"}, 64'(stall), 64'd0);
    end
    @(negedge clk);
    if (hold) begin
      issue_a = 32'hDEAD_BEEF;
      issue_b = 32'h1234_5678;
    end else begin
      issue_valid = 1'b0;
    end
    #1;
    check({tag, " clear busy"}, 64'(busy), 64'd1);
    check({tag, " clear enable"}, 64'(mult_enable), 64'd0);
    check({tag, " mult_a"}, 64'(mult_a), 64'(a));
    check({tag, " mult_b"}, 64'(mult_b), 64'(b));
    check({tag, " mult_sign"}, 64'(mult_sign), 64'(sgn));
    cyc = 0;
    stall_ok = 1'b1;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == 2)
        check({tag, " run enable"}, 64'(mult_enable), 64'd1);
      if (hold && !stall)
        stall_ok = 1'b0;
      @(negedge clk);
      #1;
    end
    issue_valid = 1'b0;
    #1;
    check({tag, " busy cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
    check({tag, " ready after"}, 64'(issue_ready), 64'd1);
    check({tag, " stall after"}, 64'(stall), 64'd0);
    check({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
    if (hold) begin
      check({tag, " stall held"}, 64'(stall_ok), 64'd1);
      check({tag, " read new hi"}, 64'(rd_data), 64'(ehi));
      check({tag, " operands kept"}, 64'(mult_a), 64'(a));
    end
    rd_hi_req = 1'b0;
    mdl_stale = 1'b0;
    cur_hi = ehi;
    cur_lo = elo;
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst issue_ready", 64'(issue_ready), 64'd1);
    check("rst enable", 64'(mult_enable), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst mult_a", 64'(mult_a), 64'd0);
    check("rst timeout_err", 64'(timeout_err), 64'd0);
    check("rst rd_data", 64'(rd_data), 64'd0);
    reset_n = 1'b1;

    do_mult("u3x2",    1'b0, 32'd3,          32'd2,          1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0006);
    do_mult("s-8x2",   1'b1, 32'hFFFF_FFF8, 32'd2,          3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    do_mult("s-14x-8", 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFF8, 2, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0070);
    do_mult("umax2",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);

    @(negedge clk);
    rd_hi_req = 1'b1;
    rd_lo_req = 1'b1;
    #1;
    check("both reqs", 64'(rd_data), 64'hFFFF_FFFE);
    rd_hi_req = 1'b0;
    #1;
    check("lo req", 64'(rd_data), 64'h0000_0001);
    rd_lo_req = 1'b0;
    #1;
    check("no req", 64'(rd_data), 64'd0);

    do_mult("smax2",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001);
    do_mult("u7x9",    1'b0, 32'd7,          32'd9,          4, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_003F);

`ifdef HILO_TIMEOUT_EN
    mdl_lat = 1000;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_sign  = 1'b0;
    issue_a     = 32'd5;
    issue_b     = 32'd5;
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("to busy cycles", 64'(cyc), 64'd41);
    check("to busy", 64'(busy), 64'd0);
    check("to err", 64'(timeout_err), 64'd1);
    check("to hi kept", 64'(hi), 64'(cur_hi));
    check("to lo kept", 64'(lo), 64'(cur_lo));
    repeat (2) @(negedge clk);
    #1;
    check("to err sticky", 64'(timeout_err), 64'd1);
`endif

    mdl_lat = 50;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_sign  = 1'b0;
    issue_a     = 32'd11;
    issue_b     = 32'd13;
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid busy", 64'(busy), 64'd1);
    check("mid enable", 64'(mult_enable), 64'd1);
    reset_n = 1'b0;
    #1;
    check("arst enable", 64'(mult_enable), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst hi", 64'(hi), 64'd0);
    check("arst lo", 64'(lo), 64'd0);
    check("arst timeout_err", 64'(timeout_err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    @(negedge clk);
    #1;
    check("post-rst idle", 64'(busy), 64'd0);
    check("post-rst hi", 64'(hi), 64'd0);

    do_mult("recover", 1'b1, 32'h8000_0000, 32'd2, 2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
